// File: rtl/serial_pkg.sv
// Shared serial-link definitions used by the transmitter and the team's receiver.
package serial_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 651;
    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned FRAME_BITS       = 10;
    localparam int unsigned BIT_IDX_W        = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/serial_baud.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled, tick on the terminal count.
module serial_baud
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tick_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term   = (r_cnt == LAST);
    assign o_tick_c = i_en & w_term;
    assign o_cnt    = r_cnt;

    // Clear has priority so an accepted start always begins a bit at count 0.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_term ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_t.sv
// Serial transmitter: start bit, 8 data bits MSB first, stop bit; TXD fully registered.
module serial_t
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 m_clock,
    input  logic                 p_reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 start,
    output logic                 TXD,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned      CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] PENULT = CNT_W'(CLKS_PER_BIT - 2);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [BIT_IDX_W-1:0]   r_bit_idx;
    logic [BIT_IDX_W-1:0]   w_bit_idx_nxt;
    logic                   r_txd;
    logic                   w_txd_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_baud_clr;
    logic                   w_baud_en;
    logic                   w_tick;
    logic [CNT_W-1:0]       w_cnt;

    assign w_baud_en = (r_state != ST_IDLE);

    serial_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .m_clock  (m_clock),
        .p_reset  (p_reset),
        .i_clear  (w_baud_clr),
        .i_en     (w_baud_en),
        .o_cnt    (w_cnt),
        .o_tick_c (w_tick)
    );

    // Registered state and outputs.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_txd     <= w_txd_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; done is set one count early so it lands on the last stop cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_txd_nxt     = r_txd;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_baud_clr    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_txd_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                w_baud_clr = 1'b1;
                if (start) begin
                    w_state_nxt   = ST_START;
                    w_shift_nxt   = data;
                    w_bit_idx_nxt = '0;
                    w_txd_nxt     = 1'b0;
                    w_busy_nxt    = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = '0;
                    w_txd_nxt     = r_shift[DATA_BITS-1];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                        w_state_nxt = ST_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + BIT_IDX_W'(1);
                        w_shift_nxt   = {r_shift[DATA_BITS-2:0], 1'b0};
                        w_txd_nxt     = r_shift[DATA_BITS-2];
                    end
                end
            end
            ST_STOP: begin
                w_txd_nxt = 1'b1;
                if (w_cnt == PENULT) begin
                    w_done_nxt = 1'b1;
                end
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_txd_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign TXD  = r_txd;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_serial_t.sv
// Directed bench for serial_t: frame timing, bit order, ignored starts, divisor extremes, reset abort, loopback.
module tb_serial_t;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 9 is the first bit on the line (start bit)
    } vec_t;

    logic m_clock;
    logic p_reset;
    logic st    [3];
    logic [7:0] dt [3];
    logic txd_a [3];
    logic busy_a[3];
    logic done_a[3];

    int checks;
    int failures;

    serial_t #(.CLKS_PER_BIT(4)) dut (
        .m_clock (m_clock), .p_reset (p_reset), .data (dt[0]), .start (st[0]),
        .TXD (txd_a[0]), .busy (busy_a[0]), .done (done_a[0])
    );

    serial_t #(.CLKS_PER_BIT(2)) dut2 (
        .m_clock (m_clock), .p_reset (p_reset), .data (dt[1]), .start (st[1]),
        .TXD (txd_a[1]), .busy (busy_a[1]), .done (done_a[1])
    );

    serial_t #(.CLKS_PER_BIT(651)) dut651 (
        .m_clock (m_clock), .p_reset (p_reset), .data (dt[2]), .start (st[2]),
        .TXD (txd_a[2]), .busy (busy_a[2]), .done (done_a[2])
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // mode 0: start pulse; mode 1: start held high; mode 2: extra start pulses and data change mid-frame.
    task automatic run_frame(input int w, input int cpb, input logic [7:0] d,
                             input logic [9:0] fr, input int mode, input string tag);
        int good [10];
        int busy_err;
        int done_err;
        int b;
        int ph;
        logic [7:0] rx;
        for (int i = 0; i < 10; i++) good[i] = 0;
        busy_err = 0;
        done_err = 0;
        rx = 8'h00;
        dt[w] = d;
        st[w] = 1'b1;
        @(posedge m_clock);
        for (int n = 1; n <= 10*cpb + 1; n++) begin
            @(negedge m_clock);
            if (mode == 0) begin
                st[w] = 1'b0;
            end else if (mode == 2) begin
                st[w] = (n == 5 || n == 20 || n == 40);
                if (n >= 5) dt[w] = 8'h3C;
            end
            if (n <= 10*cpb) begin
                b  = (n - 1) / cpb;
                ph = (n - 1) % cpb;
                if (txd_a[w] == fr[9-b]) good[b]++;
                if (busy_a[w] !== 1'b1) busy_err++;
                if (done_a[w] !== (n == 10*cpb)) done_err++;
                if (ph == cpb/2 && b >= 1 && b <= 8) rx[8-b] = txd_a[w];
            end else begin
                check({tag, " busy after done"}, int'(busy_a[w]), 0);
                check({tag, " TXD idle after frame"}, int'(txd_a[w]), 1);
                check({tag, " done after frame"}, int'(done_a[w]), 0);
            end
        end
        for (int i = 0; i < 10; i++)
            check($sformatf("%s bit%0d cycles correct", tag, i), good[i], cpb);
        check({tag, " busy low cycles in frame"}, busy_err, 0);
        check({tag, " done misplaced cycles"}, done_err, 0);
        check({tag, " received byte"}, int'(rx), int'(d));
        if (mode == 2) begin
            @(negedge m_clock);
            check({tag, " no extra frame busy"}, int'(busy_a[w]), 0);
            check({tag, " no extra frame TXD"}, int'(txd_a[w]), 1);
        end
    endtask

    vec_t vecs [5];

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{data: 8'hA5, frame: 10'b0101001011};
        vecs[1] = '{data: 8'h00, frame: 10'b0000000001};
        vecs[2] = '{data: 8'h55, frame: 10'b0010101011};
        vecs[3] = '{data: 8'hFF, frame: 10'b0111111111};
        vecs[4] = '{data: 8'h81, frame: 10'b0100000011};

        p_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            dt[i] = 8'h00;
        end
        repeat (2) @(negedge m_clock);
        check("reset TXD", int'(txd_a[0]), 1);
        check("reset busy", int'(busy_a[0]), 0);
        check("reset done", int'(done_a[0]), 0);
        check("reset TXD cpb2", int'(txd_a[1]), 1);
        check("reset TXD cpb651", int'(txd_a[2]), 1);
        p_reset = 1'b0;
        @(negedge m_clock);

        // single frames and loopback bytes
        for (int i = 0; i < 5; i++)
            run_frame(0, 4, vecs[i].data, vecs[i].frame, 0, $sformatf("vec%0d", i));

        // back-to-back with start held high
        run_frame(0, 4, 8'h00, 10'b0000000001, 1, "b2b first");
        run_frame(0, 4, 8'hFF, 10'b0111111111, 0, "b2b second");

        // ignored start requests and mid-frame data change
        run_frame(0, 4, 8'hA5, 10'b0101001011, 2, "ignore");

        // divisor extremes
        run_frame(1, 2,   8'h80, 10'b0100000001, 0, "cpb2");
        run_frame(2, 651, 8'h80, 10'b0100000001, 0, "cpb651");

        // asynchronous reset in the middle of the start bit
        dt[0] = 8'hA5;
        st[0] = 1'b1;
        @(posedge m_clock);
        @(negedge m_clock);
        st[0] = 1'b0;
        @(negedge m_clock);
        check("pre-reset TXD start bit", int'(txd_a[0]), 0);
        check("pre-reset busy", int'(busy_a[0]), 1);
        p_reset = 1'b1;
        #1;
        check("async reset TXD", int'(txd_a[0]), 1);
        check("async reset busy", int'(busy_a[0]), 0);
        check("async reset done", int'(done_a[0]), 0);
        repeat (3) @(negedge m_clock);
        check("held reset busy", int'(busy_a[0]), 0);
        p_reset = 1'b0;
        @(negedge m_clock);
        check("post-reset idle busy", int'(busy_a[0]), 0);
        run_frame(0, 4, 8'hA5, 10'b0101001011, 0, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
